shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 153 +++++++++++++++
 tb/tb_shift_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined barrel shifter (SLL / SRA / ROR / SRL)
// with valid/ready handshakes on both sides and a sideband tag.
// Stage S1 shifts by shamt[1:0]; stage S2 shifts by 4*shamt[SHAMT_W-1:2].
// The original sign bit travels with the operation so that a two-step SRA
// equals a single arithmetic shift by the full amount.
module shift_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int HI_W = SHAMT_W - 2;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  // Shift data by amt under mode; sign supplies the SRA fill bit.
  function automatic logic [WIDTH-1:0] shift_op(
    input logic [WIDTH-1:0]   data,
    input logic [SHAMT_W-1:0] amt,
    input logic [1:0]         mode,
    input logic               sign
  );
    logic [WIDTH-1:0] ones;
    logic [SHAMT_W:0] lamt;
    logic [WIDTH-1:0] res;
    ones = {WIDTH{1'b1}};
    // Left-shift amount completing a rotate; amt = 0 gives WIDTH, i.e. no wrap bits.
    lamt = (SHAMT_W + 1)'(WIDTH) - {1'b0, amt};
    case (mode)
      MODE_SLL: res = data << amt;
      MODE_SRA: res = (data >> amt) | (sign ? ~(ones >> amt) : {WIDTH{1'b0}});
      MODE_ROR: res = (data >> amt) | (data << lamt);
      MODE_SRL: res = data >> amt;
      default:  res = data;
    endcase
    return res;
  endfunction

  // Stage S1 state
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_data;
  logic [HI_W-1:0]    s1_hi;
  logic [1:0]         s1_mode;
  logic               s1_sign;
  logic [TAG_W-1:0]   s1_tag;

  // Stage S2 state (drives the outputs directly)
  logic               s2_valid;
  logic [WIDTH-1:0]   s2_data;
  logic               s2_zero;
  logic [TAG_W-1:0]   s2_tag;

  // Handshake and datapath combinational values
  logic               s2_adv;
  logic               s1_adv;
  logic               accept;
  logic [WIDTH-1:0]   s1_next_data;
  logic [WIDTH-1:0]   s2_next_data;
  logic               s2_next_zero;

  // Advance conditions: S2 moves when empty or drained; S1 moves when empty or S2 moves.
  always_comb begin
    s2_adv = 1'b0;
    s1_adv = 1'b0;
    accept = 1'b0;
    if (!s2_valid || out_ready) begin
      s2_adv = 1'b1;
    end else begin
      s2_adv = 1'b0;
    end
    if (!s1_valid || s2_adv) begin
      s1_adv = 1'b1;
    end else begin
      s1_adv = 1'b0;
    end
    accept = in_valid && s1_adv;
  end

  // Fine and coarse shift datapaths plus the result zero detect.
  always_comb begin
    s1_next_data = shift_op(in_data, {{HI_W{1'b0}}, in_shamt[1:0]}, in_mode,
                            in_data[WIDTH-1]);
    s2_next_data = shift_op(s1_data, {s1_hi, 2'b00}, s1_mode, s1_sign);
    s2_next_zero = (s2_next_data == {WIDTH{1'b0}});
  end

  // Stage S1 register: loads a new operation when one is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= {WIDTH{1'b0}};
      s1_hi    <= {HI_W{1'b0}};
      s1_mode  <= 2'b00;
      s1_sign  <= 1'b0;
      s1_tag   <= {TAG_W{1'b0}};
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= s1_next_data;
        s1_hi   <= in_shamt[SHAMT_W-1:2];
        s1_mode <= in_mode;
        s1_sign <= in_data[WIDTH-1];
        s1_tag  <= in_tag;
      end
    end
  end

  // Stage S2 register: takes the S1 operation when S2 may advance; holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= {WIDTH{1'b0}};
      s2_zero  <= 1'b0;
      s2_tag   <= {TAG_W{1'b0}};
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s2_next_data;
        s2_zero <= s2_next_zero;
        s2_tag  <= s1_tag;
      end
    end
  end

  // Output mapping: results come straight from S2 registers.
  always_comb begin
    in_ready  = s1_adv;
    out_valid = s2_valid;
    out_data  = s2_data;
    out_zero  = s2_zero;
    out_tag   = s2_tag;
    busy      = s1_valid | s2_valid;
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=16).
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_data_q[$];
  logic [3:0]  exp_tag_q[$];

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRA = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRL = 2'b11;

  shift_pipe #(.WIDTH(16), .SHAMT_W(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [15:0] d,
                       input logic [3:0] s, input logic [3:0] t);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
  endtask

  // Bitwise reference: each result bit picks its source bit directly.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] sh,
                                            input logic [1:0] m);
    logic [15:0] r;
    int src;
    r = 16'h0000;
    for (int j = 0; j < 16; j++) begin
      if (m == SLL) begin
        src = j - int'(sh);
        r[j] = (src >= 0) ? d[src] : 1'b0;
      end else if (m == SRL) begin
        src = j + int'(sh);
        r[j] = (src < 16) ? d[src] : 1'b0;
      end else if (m == SRA) begin
        src = j + int'(sh);
        r[j] = (src < 16) ? d[src] : d[15];
      end else begin
        src = (j + int'(sh)) % 16;
        r[j] = d[src];
      end
    end
    return r;
  endfunction

  // Single operation through an empty pipe with out_ready high: 2-cycle latency.
  task automatic run_op(input string name, input logic [1:0] m, input logic [15:0] d,
                        input logic [3:0] s, input logic [3:0] t, input logic [15:0] e);
    out_ready = 1'b1;
    offer(m, d, s, t);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(e));
    chk({name, "_zero"}, 32'(out_zero), 32'(e == 16'h0000));
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    step();
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic [15:0] rd;
    logic [3:0]  rs;
    logic [1:0]  rm;

    rst = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_shamt = 4'd0;
    in_mode = 2'b00; in_tag = 4'd0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic rotate example and boundary cases
    run_op("ror_1234", ROR, 16'h1234, 4'd4, 4'd3, 16'h4123);
    run_op("sra_15", SRA, 16'h8000, 4'd15, 4'd1, 16'hFFFF);
    run_op("srl_15", SRL, 16'h8000, 4'd15, 4'd2, 16'h0001);
    run_op("sll_15", SLL, 16'h0001, 4'd15, 4'd4, 16'h8000);
    run_op("ror_15", ROR, 16'h0001, 4'd15, 4'd5, 16'h0002);
    run_op("sll_out", SLL, 16'h8000, 4'd1, 4'd6, 16'h0000);
    run_op("sra_mixed", SRA, 16'hF0F0, 4'd5, 4'd7, 16'hFF87);
    run_op("sll0", SLL, 16'hA5C3, 4'd0, 4'd8, 16'hA5C3);
    run_op("sra0", SRA, 16'hA5C3, 4'd0, 4'd9, 16'hA5C3);
    run_op("ror0", ROR, 16'hA5C3, 4'd0, 4'd10, 16'hA5C3);
    run_op("srl0", SRL, 16'hA5C3, 4'd0, 4'd11, 16'hA5C3);

    // Backpressure: two held, third refused, drained in order without gaps
    out_ready = 1'b0;
    offer(SLL, 16'h0101, 4'd0, 4'd1);
    step();
    offer(SLL, 16'h0202, 4'd0, 4'd2);
    chk("stall_rdy2", 32'(in_ready), 32'd1);
    step();
    offer(SLL, 16'h0303, 4'd0, 4'd3);
    chk("stall_rdy3", 32'(in_ready), 32'd0);
    chk("stall_tag_a", 32'(out_tag), 32'd1);
    step();
    step();
    chk("stall_hold_valid", 32'(out_valid), 32'd1);
    chk("stall_hold_tag", 32'(out_tag), 32'd1);
    chk("stall_hold_data", 32'(out_data), 32'h0101);
    chk("stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("stall_rdy3_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain_tag2", 32'(out_tag), 32'd2);
    chk("drain_data2", 32'(out_data), 32'h0202);
    chk("drain_valid2", 32'(out_valid), 32'd1);
    step();
    chk("drain_tag3", 32'(out_tag), 32'd3);
    chk("drain_data3", 32'(out_data), 32'h0303);
    chk("drain_valid3", 32'(out_valid), 32'd1);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // Back-to-back stream of 32 random operations
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin
        rd = 16'($urandom); rs = 4'($urandom_range(0, 15)); rm = 2'($urandom_range(0, 3));
        offer(rm, rd, rs, 4'(i));
        exp_data_q.push_back(ref_shift(rd, rs, rm));
        exp_tag_q.push_back(4'(i));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 32) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(out_data), 32'(exp_data_q.pop_front()));
        chk("stream_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
      end
    end
    step();
    chk("stream_done", 32'(out_valid), 32'd0);

    // Random valid and out_ready with an in-order scoreboard
    sent = 0; recv = 0; cyc = 0;
    while (recv < 300 && cyc < 5000) begin
      in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom); in_shamt = 4'($urandom_range(0, 15));
      in_mode = 2'($urandom_range(0, 3)); in_tag = 4'(sent);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ref_shift(in_data, in_shamt, in_mode));
        exp_tag_q.push_back(in_tag);
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("rnd_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) begin
          chk("rnd_data", 32'(out_data), 32'(exp_data_q.pop_front()));
          chk("rnd_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
        end
        recv++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_recv", 32'(recv), 32'd300);
    chk("rnd_leftover", 32'(exp_data_q.size()), 32'd0);
    step();
    chk("rnd_idle", 32'(busy), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    offer(SRL, 16'hFFFF, 4'd1, 4'd12);
    step();
    offer(SLL, 16'h00FF, 4'd4, 4'd13);
    step();
    in_valid = 1'b0;
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_tag", 32'(out_tag), 32'd0);
    chk("midrst_zero", 32'(out_zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_op("post_rst_op", SRA, 16'h8421, 4'd6, 4'd14, 16'hFE10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
